neuron_argmax: RTL and testbench

- Downstream stage of the dot-product unit.
- Consumes one signed fixed-point neuron score per accepted transfer, NEURON_N scores per frame (one per output class).
- Tracks the running maximum and emits the winning class index and its score once per frame through a valid/ready output.
- Final classification stage of the digit-recognition pipeline.

---
 rtl/nn_pkg.sv | 32 +++
 rtl/sat_add_signed.sv | 32 +++
 rtl/neuron_argmax.sv | 139 +++++++++++++
 tb/tb_neuron_argmax.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants, argmax FSM state type and the signed saturating add used by the bias path.
package nn_pkg;

   localparam int NN_NEURON_N = 10;
   localparam int NN_VAL_SIZE = 26;
   localparam int NN_IDX_W    = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } argmax_state_t;

   // One extra bit of headroom exposes overflow as a disagreement between the top two sum bits
   function automatic logic [NN_VAL_SIZE-1:0] sat_add(
      input logic [NN_VAL_SIZE-1:0] a,
      input logic [NN_VAL_SIZE-1:0] b
   );
      logic [NN_VAL_SIZE:0] sum;
      sum = {a[NN_VAL_SIZE-1], a} + {b[NN_VAL_SIZE-1], b};
      if (sum[NN_VAL_SIZE] != sum[NN_VAL_SIZE-1]) begin
         if (sum[NN_VAL_SIZE]) begin
            sat_add = {1'b1, {(NN_VAL_SIZE-1){1'b0}}};
         end else begin
            sat_add = {1'b0, {(NN_VAL_SIZE-1){1'b1}}};
         end
      end else begin
         sat_add = sum[NN_VAL_SIZE-1:0];
      end
   endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational signed adder that clamps to the representable two's-complement range.
module sat_add_signed
   import nn_pkg::*;
#(
   parameter int W = NN_VAL_SIZE
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum
);

   if (W == NN_VAL_SIZE) begin : g_pkg_width
      assign o_sum = sat_add(i_a, i_b);
   end else begin : g_any_width
      logic [W:0] w_sum;

      // Same overflow rule as the package helper, for non-default widths
      always_comb begin
         w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};
         if (w_sum[W] != w_sum[W-1]) begin
            if (w_sum[W]) begin
               o_sum = {1'b1, {(W-1){1'b0}}};
            end else begin
               o_sum = {1'b0, {(W-1){1'b1}}};
            end
         end else begin
            o_sum = w_sum[W-1:0];
         end
      end
   end

endmodule

// File: rtl/neuron_argmax.sv
// Final classification stage: collects NEURON_N signed scores per frame and reports the argmax.
// Optional per-class bias table is enabled by defining NEURON_ARGMAX_BIAS_EN.
module neuron_argmax
   import nn_pkg::*;
#(
   parameter int NEURON_N = NN_NEURON_N,
   parameter int VAL_SIZE = NN_VAL_SIZE,
   parameter int IDX_W    = NN_IDX_W
) (
   input  logic                clk,
   input  logic                GlobalReset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [VAL_SIZE-1:0] value,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IDX_W-1:0]    class_idx,
   output logic [VAL_SIZE-1:0] max_value,
   output logic                busy
`ifdef NEURON_ARGMAX_BIAS_EN
   ,
   input  logic                bias_we,
   input  logic [IDX_W-1:0]    bias_addr,
   input  logic [VAL_SIZE-1:0] bias_data
`endif
);

   argmax_state_t       r_state;
   logic [IDX_W-1:0]    r_count;
   logic [IDX_W-1:0]    r_run_idx;
   logic [IDX_W-1:0]    r_class_idx;
   logic [VAL_SIZE-1:0] r_run_max;
   logic [VAL_SIZE-1:0] r_max_value;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_busy;

   logic [VAL_SIZE-1:0] w_score;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_last;
   logic                w_take;

`ifdef NEURON_ARGMAX_BIAS_EN
   logic [VAL_SIZE-1:0] r_bias [NEURON_N];

   // Bias table write port; the score path reads the value held before this edge
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         for (int i = 0; i < NEURON_N; i++) begin
            r_bias[i] <= '0;
         end
      end else if (bias_we && (int'(bias_addr) < NEURON_N)) begin
         r_bias[bias_addr] <= bias_data;
      end
   end

   // r_count is 0 in IDLE, so it always names the class of the score on the bus
   sat_add_signed #(.W(VAL_SIZE)) u_bias_add (
      .i_a   (value),
      .i_b   (r_bias[r_count]),
      .o_sum (w_score)
   );
`else
   assign w_score = value;
`endif

   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   assign w_last     = (r_count == IDX_W'(NEURON_N - 1));
   assign w_take     = $signed(w_score) > $signed(r_run_max);

   // Frame collection FSM; strict greater-than keeps the lowest index on ties
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_run_idx   <= '0;
         r_run_max   <= '0;
         r_class_idx <= '0;
         r_max_value <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_in_fire) begin
                  r_run_max <= w_score;
                  r_run_idx <= '0;
                  r_count   <= IDX_W'(1);
                  r_busy    <= 1'b1;
                  r_state   <= COLLECT;
               end
            end
            COLLECT: begin
               if (w_in_fire) begin
                  if (w_last) begin
                     r_max_value <= w_take ? w_score : r_run_max;
                     r_class_idx <= w_take ? r_count : r_run_idx;
                     r_out_valid <= 1'b1;
                     r_in_ready  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_count     <= '0;
                     r_state     <= HOLD;
                  end else begin
                     if (w_take) begin
                        r_run_max <= w_score;
                        r_run_idx <= r_count;
                     end
                     r_count <= r_count + IDX_W'(1);
                  end
               end
            end
            HOLD: begin
               if (w_out_fire) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_count     <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign class_idx = r_class_idx;
   assign max_value = r_max_value;
   assign busy      = r_busy;

endmodule

// File: tb/tb_neuron_argmax.sv
// Self-checking bench for neuron_argmax: directed scenarios plus random frames against an argmax model.
module tb_neuron_argmax;

   localparam int N  = 10;
   localparam int VW = 26;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          GlobalReset;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] value;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] class_idx;
   logic [VW-1:0] max_value;
   logic          busy;
`ifdef NEURON_ARGMAX_BIAS_EN
   logic          bias_we;
   logic [IW-1:0] bias_addr;
   logic [VW-1:0] bias_data;
`endif

   int errors = 0;
   int checks = 0;

   logic [VW-1:0] frame [N];
   longint        bias_m [N];

   neuron_argmax dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .value       (value),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .class_idx   (class_idx),
      .max_value   (max_value),
      .busy        (busy)
`ifdef NEURON_ARGMAX_BIAS_EN
      ,
      .bias_we     (bias_we),
      .bias_addr   (bias_addr),
      .bias_data   (bias_data)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1);
   end

   // Reference: saturate the exact sum into the signed score range
   function automatic longint sat_ref(input longint v);
      if (v > 64'sd33554431) return 64'sd33554431;
      if (v < -64'sd33554432) return -64'sd33554432;
      return v;
   endfunction

   // Reference argmax over the current frame: first strictly-larger score wins
   task automatic model(output logic [IW-1:0] e_idx, output logic [VW-1:0] e_max);
      longint best;
      longint s;
      int     bi;
      best = 0;
      bi   = 0;
      for (int i = 0; i < N; i++) begin
         s = sat_ref(longint'($signed(frame[i])) + bias_m[i]);
         if (i == 0 || s > best) begin
            best = s;
            bi   = i;
         end
      end
      e_idx = IW'(bi);
      e_max = VW'(best);
   endtask

   task automatic do_reset();
      GlobalReset = 1'b1;
      in_valid    = 1'b0;
      value       = '0;
      out_ready   = 1'b1;
`ifdef NEURON_ARGMAX_BIAS_EN
      bias_we     = 1'b0;
      bias_addr   = '0;
      bias_data   = '0;
`endif
      for (int i = 0; i < N; i++) bias_m[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      GlobalReset = 1'b0;
   endtask

   // Drives the frame[] scores; every wait for in_ready is bounded
   task automatic push_frame(input bit gapped, output bit ok, output int early, output int waits);
      int w;
      ok    = 1'b1;
      early = 0;
      waits = 0;
      for (int i = 0; i < N; i++) begin
         if (gapped && i > 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (out_valid) early++;
         end
         value    = frame[i];
         in_valid = 1'b1;
         w = 0;
         while (in_ready !== 1'b1 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
         end
         waits += w;
         if (w >= 200) ok = 1'b0;
         @(posedge clk);
         #1;
         if (i < N - 1 && out_valid) early++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (class_idx !== 4'd0) begin errors++; $display("FAIL reset_class_idx: got %0d want 0", class_idx); end
      checks++; if (max_value !== 26'h0) begin errors++; $display("FAIL reset_max_value: got %h want 0", max_value); end
   endtask

   task automatic test_ascending();
      bit ok;
      int early;
      int waits;
      for (int i = 0; i < N; i++) frame[i] = 26'(i << 18);
      out_ready = 1'b1;
      push_frame(1'b0, ok, early, waits);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL asc_accept: timeout %b want no timeout", ~ok); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL asc_out_valid: got %b want 1", out_valid); end
      checks++; if (class_idx !== 4'd9) begin errors++; $display("FAIL asc_class_idx: got %0d want 9", class_idx); end
      checks++; if (max_value !== 26'h0240000) begin errors++; $display("FAIL asc_max_value: got %h want 0240000", max_value); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL asc_hold_flags: got in_ready=%b busy=%b want 0 0", in_ready, busy); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL asc_single_pulse: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_tie_negative();
      bit ok;
      int early;
      int waits;
      for (int i = 0; i < N; i++) frame[i] = 26'h3FC0000;
      frame[3] = 26'h3FE0000;
      frame[7] = 26'h3FE0000;
      out_ready = 1'b1;
      push_frame(1'b0, ok, early, waits);
      checks++; if (out_valid !== 1'b1 || class_idx !== 4'd3) begin errors++; $display("FAIL tie_class_idx: got valid=%b idx=%0d want 1 3", out_valid, class_idx); end
      checks++; if (max_value !== 26'h3FE0000) begin errors++; $display("FAIL tie_max_value: got %h want 3FE0000", max_value); end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) frame[i] = 26'h2000000;
      push_frame(1'b0, ok, early, waits);
      checks++; if (class_idx !== 4'd0 || max_value !== 26'h2000000) begin errors++; $display("FAIL most_negative: got idx=%0d max=%h want 0 2000000", class_idx, max_value); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      bit            ok;
      int            early;
      int            waits;
      logic [IW-1:0] e_idx;
      logic [VW-1:0] e_max;
      logic [VW-1:0] second [N];
      for (int i = 0; i < N; i++) frame[i] = 26'($urandom);
      model(e_idx, e_max);
      for (int i = 0; i < N; i++) second[i] = 26'($urandom);
      out_ready = 1'b0;
      push_frame(1'b0, ok, early, waits);
      value    = second[0];
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || class_idx !== e_idx || max_value !== e_max) begin
            errors++;
            $display("FAIL bp_hold_c%0d: got rdy=%b vld=%b idx=%0d max=%h want 0 1 %0d %h", c, in_ready, out_valid, class_idx, max_value, e_idx, e_max);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
      for (int i = 0; i < N; i++) frame[i] = second[i];
      model(e_idx, e_max);
      push_frame(1'b0, ok, early, waits);
      checks++; if (out_valid !== 1'b1 || class_idx !== e_idx || max_value !== e_max) begin errors++; $display("FAIL bp_second: got vld=%b idx=%0d max=%h want 1 %0d %h", out_valid, class_idx, max_value, e_idx, e_max); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_gapped();
      bit ok;
      int early;
      int waits;
      frame[0] = 26'h1FFFFFF;
      for (int i = 1; i < N; i++) frame[i] = 26'($urandom);
      out_ready = 1'b1;
      push_frame(1'b1, ok, early, waits);
      checks++; if (early !== 0) begin errors++; $display("FAIL gap_premature: got %0d early out_valid cycles want 0", early); end
      checks++; if (out_valid !== 1'b1 || class_idx !== 4'd0 || max_value !== 26'h1FFFFFF) begin errors++; $display("FAIL gap_result: got vld=%b idx=%0d max=%h want 1 0 1FFFFFF", out_valid, class_idx, max_value); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int early;
      int waits;
      for (int i = 0; i < 4; i++) begin
         value    = (i == 1) ? 26'h1FFFFFF : 26'($urandom);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
      GlobalReset = 1'b1;
      @(posedge clk);
      #1;
      GlobalReset = 1'b0;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_reset: got busy=%b rdy=%b vld=%b want 0 1 0", busy, in_ready, out_valid); end
      for (int i = 0; i < N; i++) frame[i] = 26'($urandom_range(0, 1048575));
      frame[5] = 26'h0400000;
      push_frame(1'b0, ok, early, waits);
      checks++; if (early !== 0 || out_valid !== 1'b1 || class_idx !== 4'd5 || max_value !== 26'h0400000) begin errors++; $display("FAIL mid_new_frame: got early=%0d vld=%b idx=%0d max=%h want 0 1 5 0400000", early, out_valid, class_idx, max_value); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      bit            ok;
      int            early;
      int            waits;
      logic [IW-1:0] e_idx;
      logic [VW-1:0] e_max;
      out_ready = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < N; i++) frame[i] = 26'($urandom);
         model(e_idx, e_max);
         push_frame(1'b0, ok, early, waits);
         if (f == 1) begin
            checks++; if (waits !== 1) begin errors++; $display("FAIL b2b_spacing: got %0d stall cycles want 1", waits); end
         end
         checks++; if (out_valid !== 1'b1 || class_idx !== e_idx || max_value !== e_max) begin errors++; $display("FAIL b2b_f%0d: got vld=%b idx=%0d max=%h want 1 %0d %h", f, out_valid, class_idx, max_value, e_idx, e_max); end
      end
      @(posedge clk);
      #1;
   endtask

`ifdef NEURON_ARGMAX_BIAS_EN
   task automatic write_bias(input logic [IW-1:0] addr, input logic [VW-1:0] data);
      bias_we   = 1'b1;
      bias_addr = addr;
      bias_data = data;
      @(posedge clk);
      #1;
      bias_we = 1'b0;
      bias_m[addr] = longint'($signed(data));
   endtask

   task automatic test_bias();
      bit ok;
      int early;
      int waits;
      out_ready = 1'b1;
      write_bias(4'd2, 26'h0080000);
      for (int i = 0; i < N; i++) frame[i] = 26'h0040000;
      push_frame(1'b0, ok, early, waits);
      checks++; if (class_idx !== 4'd2 || max_value !== 26'h00C0000) begin errors++; $display("FAIL bias_plus2: got idx=%0d max=%h want 2 00C0000", class_idx, max_value); end
      @(posedge clk);
      #1;
      write_bias(4'd2, 26'h0);
      write_bias(4'd4, 26'h1FC0000);
      for (int i = 0; i < N; i++) frame[i] = 26'h1FC0000;
      push_frame(1'b0, ok, early, waits);
      checks++; if (class_idx !== 4'd4 || max_value !== 26'h1FFFFFF) begin errors++; $display("FAIL bias_saturate: got idx=%0d max=%h want 4 1FFFFFF", class_idx, max_value); end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) write_bias(IW'(i), 26'($urandom));
   endtask
`endif

   task automatic test_random();
      bit            ok;
      int            early;
      int            waits;
      int            mode;
      logic [IW-1:0] e_idx;
      logic [VW-1:0] e_max;
      logic [VW-1:0] pick [4];
      pick[0] = 26'h2000000;
      pick[1] = 26'h1FFFFFF;
      pick[2] = 26'h0000000;
      pick[3] = 26'h3FFFFFF;
      for (int f = 0; f < 12; f++) begin
         mode = $urandom_range(0, 1);
         for (int i = 0; i < N; i++) frame[i] = (mode == 0) ? 26'($urandom) : pick[$urandom_range(0, 3)];
         model(e_idx, e_max);
         out_ready = 1'($urandom_range(0, 1));
         push_frame(1'($urandom_range(0, 1)), ok, early, waits);
         checks++; if (ok !== 1'b1 || early !== 0 || out_valid !== 1'b1 || class_idx !== e_idx || max_value !== e_max) begin errors++; $display("FAIL rand_f%0d: got ok=%b early=%0d vld=%b idx=%0d max=%h want 1 0 1 %0d %h", f, ok, early, out_valid, class_idx, max_value, e_idx, e_max); end
         if (out_ready == 1'b0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || class_idx !== e_idx || max_value !== e_max) begin errors++; $display("FAIL rand_hold_f%0d: got vld=%b idx=%0d max=%h want 1 %0d %h", f, out_valid, class_idx, max_value, e_idx, e_max); end
            out_ready = 1'b1;
         end
         @(posedge clk);
         #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain_f%0d: got vld=%b want 0", f, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_ascending();
      test_tie_negative();
      test_backpressure();
      test_gapped();
      test_reset_mid_frame();
      test_back_to_back();
`ifdef NEURON_ARGMAX_BIAS_EN
      test_bias();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
